// File: rtl/ioports_link_pkg.sv
// Shared command codes, FSM encoding and byte helpers for the I/O port link arbiter.
package ioports_link_pkg;

  localparam logic [2:0] CMD_RESET = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_READ  = 3'b011;
  localparam logic [3:0] HWID_ADDR = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RD_REQ,
    ST_RD_REL,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic [2:0] code, input logic [3:0] addr);
    return {1'b0, code, addr};
  endfunction

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ioports_link_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; pointer remembers the last requester served.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       update,
  input  logic       update_idx,
  output logic [1:0] grant_c
);

  logic       last_idx;
  logic [1:0] eff_req;

  assign eff_req = req & ~mask;

  always_comb begin
    grant_c = eff_req;
    if (eff_req == 2'b11) grant_c = last_idx ? 2'b01 : 2'b10;
  end

  // Reset points at B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)       last_idx <= 1'b1;
    else if (update) last_idx <= update_idx;
  end

endmodule

// File: rtl/ioports_link_arbiter.sv
// Shares the byte-serial I/O port link between requesters A and B.
// Optional SOFT_RESET_CMD_EN adds a soft-reset command requester with top priority.
module ioports_link_arbiter
  import ioports_link_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SOFT_RESET_CMD_EN
  input  logic        soft_rst_req,
  output logic        soft_rst_done,
`endif
  input  logic        a_req,
  input  logic        a_we,
  input  logic [3:0]  a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_done,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [3:0]  b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        link_load,
  output logic [7:0]  link_datain,
  output logic        link_ready,
  input  logic        link_enout,
  input  logic [7:0]  link_dataout
);

  localparam int unsigned GAP_W     = $clog2(GAP_CYCLES + 2);
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             state;
  logic               owner;
  logic               soft_op;
  logic               cur_we;
  logic [3:0]         cur_addr;
  logic [31:0]        cur_wdata;
  logic [1:0]         byte_cnt;
  logic [7:0]         wait_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_last_c;
  logic [31:0]        rbuf;
  logic               rd_err;
  logic [1:0]         grant_c;
  logic               sel_b_c;
  logic               sel_we_c;
  logic [3:0]         sel_addr_c;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({b_req, a_req}),
    .mask       ({b_done, a_done}),
    .update     ((state == ST_DONE) && !soft_op),
    .update_idx (owner),
    .grant_c    (grant_c)
  );

  assign sel_b_c    = grant_c[1];
  assign sel_we_c   = sel_b_c ? b_we : a_we;
  assign sel_addr_c = sel_b_c ? b_addr : a_addr;

  // The I/O block ignores load for one cycle after a write to port f.
  assign gap_last_c = GAP_W'(GAP_CYCLES - 1) +
                      GAP_W'(cur_we && (cur_addr == HWID_ADDR) && !soft_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      soft_op     <= 1'b0;
      cur_we      <= 1'b0;
      cur_addr    <= '0;
      cur_wdata   <= '0;
      byte_cnt    <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      rbuf        <= '0;
      rd_err      <= 1'b0;
      a_done      <= 1'b0;
      a_rdata     <= '0;
      a_err       <= 1'b0;
      b_done      <= 1'b0;
      b_rdata     <= '0;
      b_err       <= 1'b0;
      link_load   <= 1'b0;
      link_datain <= '0;
      link_ready  <= 1'b0;
`ifdef SOFT_RESET_CMD_EN
      soft_rst_done <= 1'b0;
`endif
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
`ifdef SOFT_RESET_CMD_EN
      soft_rst_done <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          link_load   <= 1'b0;
          link_ready  <= 1'b0;
          link_datain <= '0;
`ifdef SOFT_RESET_CMD_EN
          if (soft_rst_req) begin
            soft_op     <= 1'b1;
            cur_we      <= 1'b0;
            cur_addr    <= '0;
            link_load   <= 1'b1;
            link_datain <= cmd_byte(CMD_RESET, 4'd0);
            state       <= ST_CMD;
          end else
`endif
          if (|grant_c) begin
            soft_op     <= 1'b0;
            owner       <= sel_b_c;
            cur_we      <= sel_we_c;
            cur_addr    <= sel_addr_c;
            cur_wdata   <= sel_b_c ? b_wdata : a_wdata;
            link_load   <= 1'b1;
            link_datain <= cmd_byte(sel_we_c ? CMD_WRITE : CMD_READ, sel_addr_c);
            state       <= ST_CMD;
          end
        end
        ST_CMD: begin
          byte_cnt <= '0;
          wait_cnt <= '0;
          rd_err   <= 1'b0;
          rbuf     <= '0;
          if (soft_op) begin
            link_load   <= 1'b0;
            link_datain <= '0;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end else if (cur_we) begin
            link_load   <= 1'b1;
            link_datain <= word_byte(cur_wdata, 2'd0);
            state       <= ST_WDATA;
          end else begin
            link_load   <= 1'b0;
            link_datain <= '0;
            link_ready  <= 1'b1;
            state       <= ST_RD_REQ;
          end
        end
        ST_WDATA: begin
          if (byte_cnt == 2'd3) begin
            link_load   <= 1'b0;
            link_datain <= '0;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end else begin
            byte_cnt    <= byte_cnt + 2'd1;
            link_datain <= word_byte(cur_wdata, byte_cnt + 2'd1);
          end
        end
        ST_RD_REQ: begin
          if (link_enout) begin
            rbuf       <= put_byte(rbuf, byte_cnt, link_dataout);
            link_ready <= 1'b0;
            wait_cnt   <= '0;
            state      <= ST_RD_REL;
          end else if (wait_cnt == WAIT_LAST) begin
            link_ready <= 1'b0;
            rd_err     <= 1'b1;
            gap_cnt    <= '0;
            state      <= ST_GAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RD_REL: begin
          if (!link_enout) begin
            wait_cnt <= '0;
            if (byte_cnt == 2'd3) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              byte_cnt   <= byte_cnt + 2'd1;
              link_ready <= 1'b1;
              state      <= ST_RD_REQ;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            rd_err  <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == gap_last_c) begin
            state <= ST_DONE;
            if (soft_op) begin
`ifdef SOFT_RESET_CMD_EN
              soft_rst_done <= 1'b1;
`endif
            end else if (owner) begin
              b_done <= 1'b1;
              b_err  <= rd_err;
              if (!cur_we) b_rdata <= rd_err ? 32'd0 : rbuf;
            end else begin
              a_done <= 1'b1;
              a_err  <= rd_err;
              if (!cur_we) a_rdata <= rd_err ? 32'd0 : rbuf;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
